// File: rtl/led_counter_pkg.sv
// Shared constants and helpers for the icestick LED counter.
package led_counter_pkg;

  localparam int LED_W = 5;

  // The prescaler counter needs at least one bit, even when DIV is 1.
  function automatic int div_cnt_w(input int div);
    if (div <= 1) begin
      return 1;
    end else begin
      return $clog2(div);
    end
  endfunction

endpackage

// File: rtl/led_counter_tick_gen.sv
// Prescaler: emits a one-cycle tick every DIV clock cycles.
module tick_gen
  import led_counter_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int            CW   = div_cnt_w(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  if (DIV < 1) begin : g_bad_div
    $error("tick_gen: DIV must be >= 1");
  end

  logic [CW-1:0] div_cnt_q;
  logic [CW-1:0] div_cnt_d;

  assign tick = (div_cnt_q == LAST);

  // Next prescaler phase; with DIV=1 LAST is 0, so the counter stays at 0.
  always_comb begin
    div_cnt_d = div_cnt_q;
    if (tick) begin
      div_cnt_d = '0;
    end else begin
      div_cnt_d = div_cnt_q + CW'(1);
    end
  end

  // Prescaler phase register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: rtl/led_counter.sv
// Free-running 5-bit LED counter advanced by a prescaled tick.
module led_counter
  import led_counter_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic             clk,
  input  logic             rst,
  output logic [LED_W-1:0] led
);

  logic             tick;
  logic [LED_W-1:0] led_q;
  logic [LED_W-1:0] led_d;

  tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Next count; natural 5-bit overflow wraps 31 to 0.
  always_comb begin
    led_d = led_q;
    if (tick) begin
      led_d = led_q + LED_W'(1);
    end else begin
      led_d = led_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led_q <= '0;
    end else begin
      led_q <= led_d;
    end
  end

  assign led = led_q;

endmodule

// File: tb/tb_led_counter.sv
// Self-checking bench: DIV=1 and DIV=4 instances against an edge-count model.
module tb_led_counter;

  logic       clk     = 1'b0;
  logic       clk_run = 1'b1;
  logic       rst1    = 1'b0;
  logic       rst4    = 1'b0;
  logic [4:0] led1;
  logic [4:0] led4;
  int         n1      = 0;
  int         n4      = 0;
  int         passed  = 0;
  int         total   = 0;
  int         ticks   = 0;

  led_counter #(.DIV(1)) dut1 (.clk(clk), .rst(rst1), .led(led1));
  led_counter #(.DIV(4)) dut4 (.clk(clk), .rst(rst4), .led(led4));

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  // Model: led = floor(edges since release / DIV) mod 32.
  function automatic logic [4:0] model(input int n, input int div);
    int v;
    v = (n / div) % 32;
    return v[4:0];
  endfunction

  task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance k rising edges, counting only those seen out of reset; end on a falling edge.
  task automatic edges(input int k);
    repeat (k) begin
      @(posedge clk);
      if (rst1) n1++;
      if (rst4) n4++;
    end
    @(negedge clk);
  endtask

  initial begin
    // Reset hold with the clock running.
    for (int i = 0; i < 4; i++) begin
      edges(1);
      check("hold_div1", led1, 5'd0);
      check("hold_div4", led4, 5'd0);
    end

    rst1 = 1'b1; rst4 = 1'b1; n1 = 0; n4 = 0;
    for (int i = 1; i <= 30; i++) begin
      edges(1);
      check("count_div1", led1, model(n1, 1));
      if (i == 3 || i == 4 || i == 12) check("prescale_div4", led4, model(n4, 4));
      if (i <= 16) begin
        check("tick_phase", {4'd0, dut4.u_tick.tick}, {4'd0, (n4 % 4) == 3});
        if (dut4.u_tick.tick === 1'b1) ticks++;
      end
    end
    check("count_final", led1, 5'b11110);
    check("tick_per16", ticks[4:0], 5'd4);

    edges(2);
    check("wrap32", led1, 5'd0);
    edges(1);
    check("wrap33", led1, 5'd1);

    // Mid-count async reset on DIV=4 at led=5, phase 2.
    rst4 = 1'b0; #1; rst4 = 1'b1; n4 = 0;
    edges(22);
    check("mid_led5", led4, 5'd5);
    check("mid_phase", {4'd0, dut4.u_tick.tick}, 5'd0);
    rst4 = 1'b0;
    #1;
    check("mid_async_clr", led4, 5'd0);
    #1;
    rst4 = 1'b1; n4 = 0;
    edges(3);
    check("rerelease_3", led4, 5'd0);
    edges(1);
    check("rerelease_4", led4, 5'd1);

    // Randomized run lengths with occasional resets.
    for (int it = 0; it < 24; it++) begin
      edges($urandom_range(1, 40));
      check("rand_div1", led1, model(n1, 1));
      check("rand_div4", led4, model(n4, 4));
      if ($urandom_range(0, 3) == 0) begin
        rst1 = 1'b0; rst4 = 1'b0;
        #1;
        check("rand_rst1", led1, 5'd0);
        check("rand_rst4", led4, 5'd0);
        edges($urandom_range(1, 3));
        check("rand_hold4", led4, 5'd0);
        rst1 = 1'b1; rst4 = 1'b1; n1 = 0; n4 = 0;
      end
    end

    // Reset with the clock stopped low.
    edges(9);
    clk_run = 1'b0;
    #12;
    rst1 = 1'b0; rst4 = 1'b0;
    #20;
    check("static_clr1", led1, 5'd0);
    check("static_clr4", led4, 5'd0);
    rst1 = 1'b1; rst4 = 1'b1; n1 = 0; n4 = 0;
    clk_run = 1'b1;
    edges(9);
    check("restart_div1", led1, model(n1, 1));
    check("restart_div4", led4, model(n4, 4));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
